// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM encoding for alu_seq; DIV state exists only with ALU_DIVIDER_EN.
package alu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_AND   = 5'd5;
    localparam logic [4:0] ALU_NOT   = 5'd6;
    localparam logic [4:0] ALU_XOR   = 5'd7;
    localparam logic [4:0] ALU_CMP   = 5'd8;
    localparam logic [4:0] ALU_PASS  = 5'd9;
    localparam logic [4:0] ALU_SHL   = 5'd12;
    localparam logic [4:0] ALU_SHR   = 5'd13;
    localparam logic [4:0] ALU_SRA   = 5'd14;
    localparam logic [4:0] ALU_MULH  = 5'd16;
    localparam logic [4:0] ALU_MULLO = 5'd17;
    localparam logic [4:0] ALU_MULHI = 5'd18;
    localparam logic [4:0] ALU_DIV   = 5'd20;
    localparam logic [4:0] ALU_REM   = 5'd21;

`ifdef ALU_DIVIDER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_MUL} state_t;
`endif

    function automatic logic is_mul_op(input logic [4:0] opc);
        return (opc == ALU_MULH) || (opc == ALU_MULLO) || (opc == ALU_MULHI);
    endfunction

    function automatic logic is_div_op(input logic [4:0] opc);
        return (opc == ALU_DIV) || (opc == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative unsigned restoring divider, one quotient bit per clock.
// The first bit is resolved in the start cycle so results are ready WIDTH-1 clocks later.
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    assign src_rem = start ? '0 : rem_q;
    assign src_quo = start ? a  : quo_q;
    assign src_dvs = start ? b  : dvs_q;

    // Divide by zero falls out naturally: every trial fits, giving all-ones and rem=a.
    assign shifted = {src_rem, src_quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, src_dvs};
    assign fits    = ~trial[WIDTH];
    assign rem_d   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_d   = {src_quo[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                dvs_q <= b;
                cnt_q <= CNT_FIRST;
            end else if (cnt_q != '0) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with start/done handshake, iterative multiply and
// optional iterative divide (ALU_DIVIDER_EN); ops 20/21 return 0 when the divider is absent.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic             is_zero,
    output logic             is_negative
);
    import alu_pkg::*;

    localparam int HW = WIDTH / 2;
    localparam logic [SHW:0] CNT_W   = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW + 1)'(1);

    state_t             state_q;
    logic               busy_q, done_q, zero_q, neg_q;
    logic [WIDTH-1:0]   c_q;
    logic [SHW:0]       cnt_q;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [4:0]         opc;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   diff, single_res, iter_res, mul_a, mul_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_d;
    logic               start_mul, start_div;
    logic               unused_op_hi;

    assign opc          = op[4:0];
    assign unused_op_hi = ^op[7:5];
    assign shamt        = b[SHW-1:0];
    assign diff         = a - b;

    always_comb begin
        single_res = '0;
        case (opc)
            ALU_ADD:  single_res = a + b;
            ALU_SUB:  single_res = diff;
            ALU_OR:   single_res = a | b;
            ALU_AND:  single_res = a & b;
            ALU_NOT:  single_res = ~a;
            ALU_XOR:  single_res = a ^ b;
            ALU_CMP: begin
                if (diff == '0)          single_res = '0;
                else if (diff[WIDTH-1])  single_res = '1;
                else                     single_res = {{(WIDTH-1){1'b0}}, 1'b1};
            end
            ALU_PASS: single_res = a;
            ALU_SHL:  single_res = a << shamt;
            ALU_SHR:  single_res = a >> shamt;
            ALU_SRA:  single_res = $unsigned($signed(a) >>> shamt);
            default:  single_res = '0;
        endcase
    end

    // Shift-add multiply: low half of prod_q starts as the multiplier and is consumed LSB first.
    assign mul_a   = (opc == ALU_MULH) ? {{HW{1'b0}}, a[HW-1:0]} : a;
    assign mul_b   = (opc == ALU_MULH) ? {{HW{1'b0}}, b[HW-1:0]} : b;
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

    assign start_mul = (state_q == ST_IDLE) && start && is_mul_op(opc);
`ifdef ALU_DIVIDER_EN
    logic             div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign start_div = (state_q == ST_IDLE) && start && is_div_op(opc);

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (start_div),
        .a         (a),
        .b         (b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );
`else
    assign start_div = 1'b0;
`endif

    always_comb begin
        iter_res = (op_q == ALU_MULHI) ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
`ifdef ALU_DIVIDER_EN
        if (state_q == ST_DIV) begin
            iter_res = (op_q == ALU_REM) ? div_rem : div_quo;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_mul) begin
                        op_q    <= opc;
                        mcand_q <= mul_a;
                        prod_q  <= {{WIDTH{1'b0}}, mul_b};
                        cnt_q   <= CNT_W;
                        busy_q  <= 1'b1;
                        state_q <= ST_MUL;
                    end else if (start_div) begin
                        op_q    <= opc;
                        cnt_q   <= CNT_W;
                        busy_q  <= 1'b1;
`ifdef ALU_DIVIDER_EN
                        state_q <= ST_DIV;
`endif
                    end else if (start) begin
                        c_q    <= single_res;
                        zero_q <= (single_res == '0);
                        neg_q  <= single_res[WIDTH-1];
                        done_q <= 1'b1;
                    end
                end
                ST_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        c_q     <= iter_res;
                        zero_q  <= (iter_res == '0);
                        neg_q   <= iter_res[WIDTH-1];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`ifdef ALU_DIVIDER_EN
                ST_DIV: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (div_done) begin
                        c_q     <= iter_res;
                        zero_q  <= (iter_res == '0);
                        neg_q   <= iter_res[WIDTH-1];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign c           = c_q;
    assign is_zero     = zero_q;
    assign is_negative = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32), honours ALU_DIVIDER_EN.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, is_zero, is_negative;
    logic [31:0] c;

    int vectors = 0;
    int miscompares = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .c           (c),
        .is_zero     (is_zero),
        .is_negative (is_negative)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_c(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] d;
        p = 64'(x) * 64'(y);
        d = x - y;
        case (o)
            5'd0:  return x + y;
            5'd2:  return x - y;
            5'd4:  return x | y;
            5'd5:  return x & y;
            5'd6:  return ~x;
            5'd7:  return x ^ y;
            5'd8:  return (x == y) ? 32'd0 : (d[31] ? 32'hFFFF_FFFF : 32'd1);
            5'd9:  return x;
            5'd12: return x << y[4:0];
            5'd13: return x >> y[4:0];
            5'd14: return $unsigned($signed(x) >>> y[4:0]);
            5'd16: return 32'(x[15:0]) * 32'(y[15:0]);
            5'd17: return p[31:0];
            5'd18: return p[63:32];
`ifdef ALU_DIVIDER_EN
            5'd20: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd21: return (y == 0) ? x : x % y;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o);
        if (o == 5'd16 || o == 5'd17 || o == 5'd18) return 32;
`ifdef ALU_DIVIDER_EN
        if (o == 5'd20 || o == 5'd21) return 32;
`endif
        return 0;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after the bound).
    task automatic issue(input logic [7:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         output int k, output logic busy_ok);
        start = 1'b1; op = op_v; a = a_v; b = b_v;
        @(negedge clk);
        start = 1'b0; op = 8'($urandom); a = $urandom; b = $urandom;
        k = 0;
        busy_ok = 1'b1;
        while (!done && k < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || c !== 32'd0 || is_zero !== 1'b1 || is_negative !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b done=%b c=%h z=%b n=%b, required 0 0 00000000 1 0",
                     busy, done, c, is_zero, is_negative);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          k;
        string       name;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[$];
        int k;
        logic bok;
        tbl.push_back('{8'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 0,  "add_ovf"});
        tbl.push_back('{8'd8,  32'd3,         32'd5,         32'hFFFF_FFFF, 0,  "cmp_lt"});
        tbl.push_back('{8'd8,  32'd5,         32'd5,         32'd0,         0,  "cmp_eq"});
        tbl.push_back('{8'd8,  32'd9,         32'd5,         32'd1,         0,  "cmp_gt"});
        tbl.push_back('{8'd14, 32'h8000_0000, 32'd4,         32'hF800_0000, 0,  "sra"});
        tbl.push_back('{8'd12, 32'h0000_1234, 32'd32,        32'h0000_1234, 0,  "shl_zero"});
        tbl.push_back('{8'hE0, 32'd1,         32'd2,         32'd3,         0,  "op_hi_ignored"});
        tbl.push_back('{8'd3,  32'd11,        32'd22,        32'd0,         0,  "undefined"});
        tbl.push_back('{8'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mul_hi"});
        tbl.push_back('{8'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32, "mul_lo"});
        tbl.push_back('{8'd16, 32'hABCD_0003, 32'h1234_0005, 32'd15,        32, "mul_half"});
`ifdef ALU_DIVIDER_EN
        tbl.push_back('{8'd20, 32'd100,       32'd7,         32'd14,        32, "div"});
        tbl.push_back('{8'd21, 32'd100,       32'd7,         32'd2,         32, "rem"});
        tbl.push_back('{8'd20, 32'd100,       32'd0,         32'hFFFF_FFFF, 32, "div_by_zero"});
        tbl.push_back('{8'd21, 32'd100,       32'd0,         32'd100,       32, "rem_by_zero"});
`else
        tbl.push_back('{8'd20, 32'd100,       32'd7,         32'd0,         0,  "div_absent"});
        tbl.push_back('{8'd21, 32'd100,       32'd7,         32'd0,         0,  "rem_absent"});
`endif
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, k, bok);
            vectors++;
            if (c !== tbl[i].c || is_zero !== (tbl[i].c == 0) || is_negative !== tbl[i].c[31]) begin
                miscompares++;
                $display("FAIL %s c=%h z=%b n=%b, required c=%h z=%b n=%b", tbl[i].name,
                         c, is_zero, is_negative, tbl[i].c, (tbl[i].c == 0), tbl[i].c[31]);
            end
            vectors++;
            if (k !== tbl[i].k || !bok) begin
                miscompares++;
                $display("FAIL %s_timing done after %0d edges busy_ok=%b, required %0d edges busy_ok=1",
                         tbl[i].name, k, bok, tbl[i].k);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  codes [0:22] = '{5'd0, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd12, 5'd13,
                                      5'd14, 5'd16, 5'd17, 5'd18, 5'd20, 5'd21, 5'd1, 5'd3, 5'd10,
                                      5'd11, 5'd15, 5'd19, 5'd31};
        logic [4:0]  o;
        logic [31:0] x, y, ec;
        int          k, el;
        logic        bok;
        for (int i = 0; i < 48; i++) begin
            o = codes[$urandom_range(22)];
            x = $urandom;
            y = $urandom;
            case ($urandom_range(3))
                0: y = x;
                1: y = 32'($urandom_range(40));
                default: ;
            endcase
            issue({3'($urandom), o}, x, y, k, bok);
            ec = ref_c(o, x, y);
            el = ref_lat(o);
            vectors++;
            if (c !== ec || is_zero !== (ec == 0) || is_negative !== ec[31]) begin
                miscompares++;
                $display("FAIL random op=%0d a=%h b=%h c=%h z=%b n=%b, required c=%h z=%b n=%b",
                         o, x, y, c, is_zero, is_negative, ec, (ec == 0), ec[31]);
            end
            vectors++;
            if (k !== el || !bok) begin
                miscompares++;
                $display("FAIL random_timing op=%0d done after %0d edges busy_ok=%b, required %0d",
                         o, k, bok, el);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int k;
        int extra;
        start = 1'b1; op = 8'd17; a = 32'd3; b = 32'd4;
        @(negedge clk);
        k = 0;
        while (!done && k < 200) begin
            start = (k % 4 == 1);
            op = 8'd0; a = 32'd1; b = 32'd1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        vectors++;
        if (c !== 32'd12 || k !== 32) begin
            miscompares++;
            $display("FAIL busy_ignore c=%h after %0d edges, required c=0000000c after 32", c, k);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL busy_ignore_extra_done count=%0d, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic bok;
        logic [31:0] x, y;
        issue(8'd17, 32'd5, 32'd6, k, bok);
        vectors++;
        if (c !== 32'd30 || k !== 32) begin
            miscompares++;
            $display("FAIL b2b_mul c=%h after %0d edges, required 0000001e after 32", c, k);
        end
        x = $urandom; y = $urandom;
        start = 1'b1; op = 8'd0; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || c !== x + y) begin
            miscompares++;
            $display("FAIL b2b_chain done=%b busy=%b c=%h, required 1 0 %h", done, busy, c, x + y);
        end
        for (int i = 0; i < 8; i++) begin
            x = $urandom; y = $urandom;
            start = 1'b1; op = {3'b000, 5'd7}; a = x; b = y;
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || c !== (x ^ y)) begin
                miscompares++;
                $display("FAIL throughput[%0d] done=%b c=%h, required 1 %h", i, done, c, x ^ y);
            end
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse done=%b, required 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        start = 1'b1; op = 8'd17; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || c !== 32'd0 || is_zero !== 1'b1 || is_negative !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid busy=%b done=%b c=%h z=%b n=%b, required 0 0 00000000 1 0",
                     busy, done, c, is_zero, is_negative);
        end
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_ghost cycles_with_done_or_busy=%0d, required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
